data_extreme_tracker: RTL and testbench
=======================================

DATA_EXTREME_TRACKER -- requirements
Module: data_extreme_tracker

Interface
REQ-001 The block SHALL have parameter WIN_LEN, default 8, giving the number of samples per window; the legal range is 2..255.
REQ-002 The block SHALL have port iClk  input  1  system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port iRst  input  1  reset; one clock, asynchronous and active-high.
REQ-004 The block SHALL have port iData  input  8  unsigned sample.
REQ-005 The block SHALL have port iValid  input  1  sample present on iData.
REQ-006 The block SHALL have port oReady  output  1  block can accept a sample.
REQ-007 The block SHALL have port oMax  output  8  largest sample of the window.
REQ-008 The block SHALL have port oMin  output  8  smallest sample of the window.
REQ-009 The block SHALL have port oMaxIdx  output  8  0-based index of the first occurrence of oMax in the window.
REQ-010 The block SHALL have port oCmp  output  3  one-hot relation of the last accepted sample to the running max before update: 100 greater, 010 less, 001 equal.
REQ-011 The block SHALL have port oValid  output  1  window result present.
REQ-012 The block SHALL have port iReady  input  1  consumer takes the result.

Function
REQ-013 A sample SHALL be accepted exactly on cycles with iValid=1 and oReady=1.
REQ-014 The FSM SHALL have two states: ACCUM (oReady=1, oValid=0) and HOLD (oReady=0, oValid=1).
REQ-015 In ACCUM, an internal count (0..WIN_LEN-1) SHALL increment on each accepted sample.
REQ-016 The first sample of a window (count=0) SHALL load oMax and oMin with the sample, set oMaxIdx to 0, and set oCmp to 001.
REQ-017 For a later sample, oCmp SHALL take the unsigned comparison of the sample against the current oMax.
REQ-018 When that comparison is 100 (greater), oMax SHALL take the sample and oMaxIdx SHALL take count.
REQ-019 When that comparison is 001 (equal) or 010 (less), oMax and oMaxIdx SHALL hold.
REQ-020 oMin SHALL take the sample only when the sample is strictly less than oMin.
REQ-021 Accepting a sample when count=WIN_LEN-1 SHALL move the FSM to HOLD; oValid SHALL rise on the next cycle, with final values already on oMax, oMin and oMaxIdx (latency 1).
REQ-022 In HOLD, oMax, oMin, oMaxIdx and oCmp SHALL stay stable, and iValid SHALL be ignored.
REQ-023 In HOLD, iValid/iData SHALL NOT cause a sample to be lost silently: upstream holds the sample because oReady=0.
REQ-024 In HOLD with iReady=1, the next cycle SHALL be ACCUM with count=0 and oValid=0.
REQ-025 In HOLD with iReady=0, the block SHALL remain in HOLD indefinitely.
REQ-026 Because ACCUM and HOLD are mutually exclusive, a sample SHALL never be accepted on the same cycle as a result handoff.
REQ-027 iReady SHALL have no effect in ACCUM.
REQ-028 Equal samples SHALL keep the earliest index.
REQ-029 oCmp SHALL be exactly one-hot after the first accepted sample.

Reset
REQ-030 On iRst=1, the block SHALL immediately enter ACCUM with count=0, oValid=0, oReady=1 (after release), oMax=0, oMin=8'hFF, oMaxIdx=0 and oCmp=001.
REQ-031 Reset during ACCUM or HOLD SHALL discard any partial or pending window.
REQ-032 The first rising edge after reset release SHALL be able to accept a sample.

Structure
REQ-033 A shared package data_cmp_pkg SHALL hold CMP_GT=3'b100, CMP_LT=3'b010, CMP_EQ=3'b001 and the FSM state encoding; the block SHALL use only these names.
REQ-034 A single combinational sub-module data_cmp8_core SHALL take two 8-bit unsigned inputs and produce the 3-bit one-hot code; it SHALL be instantiated once, for sample versus oMax.
REQ-035 The oMin test SHALL be a plain less-than.
REQ-036 count and oMaxIdx SHALL be 8 bits wide.

Verification
REQ-037 Scenario 1: WIN_LEN=4, samples 5,9,3,9 with iReady=1 -> oValid for 1 cycle, oMax=9, oMin=3, oMaxIdx=1, oCmp=001.
REQ-038 Scenario 2: WIN_LEN=4, samples 7,7,7,7 -> oMax=7, oMin=7, oMaxIdx=0, oCmp=001.
REQ-039 Scenario 3: WIN_LEN=4, samples 0,255,1,0 with iReady=0 for 5 cycles after oValid -> outputs held, oReady=0 throughout, iValid pulses in HOLD not counted; after iReady=1 the next window starts at index 0.
REQ-040 Scenario 4: WIN_LEN=4, iValid toggling 1,0,1,1,0,1 with samples 2,x,8,4,x,1 -> exactly four accepted, oMax=8, oMaxIdx=1, oMin=1.
REQ-041 Scenario 5: iRst asserted mid-clock after 2 of 4 samples -> outputs immediately at reset values; a fresh window 3,1,2,6 -> oMax=6, oMaxIdx=3, oMin=1.
REQ-042 Scenario 6: back-to-back windows 1,2,3,4 then 4,3,2,1 with iReady=1 -> results (4,1,3) then (4,1,0); no sample dropped or double-counted.

Source files
------------

// File: rtl/data_cmp_pkg.sv
// Shared comparison codes and FSM encoding
// for the data extreme tracker.
package data_cmp_pkg;

  localparam logic [2:0] CMP_GT = 3'b100;
  localparam logic [2:0] CMP_LT = 3'b010;
  localparam logic [2:0] CMP_EQ = 3'b001;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

endpackage

// File: rtl/data_cmp8_core.sv
// Unsigned 8-bit comparator producing a
// one-hot greater/less/equal code.
import data_cmp_pkg::*;

module data_cmp8_core (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [2:0] cmp
);

  always_comb begin
    cmp = CMP_EQ;
    unique case (1'b1)
      (a > b): cmp = CMP_GT;
      (a < b): cmp = CMP_LT;
      default: cmp = CMP_EQ;
    endcase
  end

endmodule

// File: rtl/data_extreme_tracker.sv
// Windowed max/min tracker with first-max
// index and a valid/ready result handoff.
import data_cmp_pkg::*;

module data_extreme_tracker #(
  parameter int WIN_LEN = 8
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic [7:0] iData,
  input  logic       iValid,
  output logic       oReady,
  output logic [7:0] oMax,
  output logic [7:0] oMin,
  output logic [7:0] oMaxIdx,
  output logic [2:0] oCmp,
  output logic       oValid,
  input  logic       iReady
);

  localparam logic [7:0] LAST = 8'(WIN_LEN - 1);

  state_t     state;
  logic [7:0] count;
  logic [2:0] cmpMax;
  logic       accept;

  assign accept = iValid & oReady;

  data_cmp8_core uCmp (
    .a   (iData),
    .b   (oMax),
    .cmp (cmpMax)
  );

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state   <= ACCUM;
      count   <= '0;
      oReady  <= 1'b1;
      oValid  <= 1'b0;
      oMax    <= 8'h00;
      oMin    <= 8'hFF;
      oMaxIdx <= '0;
      oCmp    <= CMP_EQ;
    end else begin
      unique case (state)
        ACCUM: begin
          if (accept) begin
            if (count == 8'd0) begin
              oMax    <= iData;
              oMin    <= iData;
              oMaxIdx <= '0;
              oCmp    <= CMP_EQ;
            end else begin
              oCmp <= cmpMax;
              if (cmpMax == CMP_GT) begin
                oMax    <= iData;
                oMaxIdx <= count;
              end
              if (iData < oMin)
                oMin <= iData;
            end
            if (count == LAST) begin
              count  <= '0;
              state  <= HOLD;
              oReady <= 1'b0;
              oValid <= 1'b1;
            end else begin
              count <= count + 8'd1;
            end
          end
        end
        HOLD: begin
          // results stay frozen until the consumer takes them
          if (iReady) begin
            state  <= ACCUM;
            oReady <= 1'b1;
            oValid <= 1'b0;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_data_extreme_tracker.sv
// Scoreboard bench for data_extreme_tracker
// with WIN_LEN=4.
module tb_data_extreme_tracker;

  localparam int WL = 4;

  typedef struct packed {
    logic [7:0] mx;
    logic [7:0] mn;
    logic [7:0] idx;
    logic [2:0] cmp;
  } res_t;

  logic       iClk = 1'b0;
  logic       iRst = 1'b1;
  logic [7:0] iData = '0;
  logic       iValid = 1'b0;
  logic       iReady = 1'b1;
  logic       oReady;
  logic [7:0] oMax;
  logic [7:0] oMin;
  logic [7:0] oMaxIdx;
  logic [2:0] oCmp;
  logic       oValid;

  int nCmp = 0;
  int nBad = 0;

  res_t q[$];
  logic [7:0] mMax, mMin, mIdx;
  logic [2:0] mCmp;
  int mCnt = 0;

  data_extreme_tracker #(.WIN_LEN(WL)) dut (
    .iClk    (iClk),
    .iRst    (iRst),
    .iData   (iData),
    .iValid  (iValid),
    .oReady  (oReady),
    .oMax    (oMax),
    .oMin    (oMin),
    .oMaxIdx (oMaxIdx),
    .oCmp    (oCmp),
    .oValid  (oValid),
    .iReady  (iReady)
  );

  always #5 iClk = ~iClk;

  task automatic modelAccept(input logic [7:0] d);
    res_t r;
    if (mCnt == 0) begin
      mMax = d;
      mMin = d;
      mIdx = 0;
      mCmp = 3'b001;
    end else begin
      if (d > mMax) mCmp = 3'b100;
      else if (d < mMax) mCmp = 3'b010;
      else mCmp = 3'b001;
      if (d > mMax) begin
        mMax = d;
        mIdx = 8'(mCnt);
      end
      if (d < mMin) mMin = d;
    end
    if (mCnt == WL - 1) begin
      r.mx = mMax;
      r.mn = mMin;
      r.idx = mIdx;
      r.cmp = mCmp;
      q.push_back(r);
      mCnt = 0;
    end else begin
      mCnt++;
    end
  endtask

  task automatic send(input logic [7:0] d);
    int n;
    @(negedge iClk);
    iValid = 1'b1;
    iData = d;
    n = 0;
    while (!oReady && n < 20) begin
      @(negedge iClk);
      n++;
    end
    nCmp++;
    if (!oReady) begin
      nBad++;
      $display("FAIL send_timeout: oReady=%0b required 1", oReady);
    end
    @(posedge iClk);
    #1;
    iValid = 1'b0;
    modelAccept(d);
  endtask

  task automatic idle();
    @(negedge iClk);
    iValid = 1'b0;
    iData = 8'hAA;
    @(posedge iClk);
    #1;
  endtask

  task automatic getResult(input string nm);
    res_t e;
    int n;
    n = 0;
    while (!oValid && n < 20) begin
      @(negedge iClk);
      n++;
    end
    nCmp++;
    if (!oValid || q.size() == 0) begin
      nBad++;
      $display("FAIL %s_valid: oValid=%0b qsize=%0d required 1/>0",
               nm, oValid, q.size());
    end else begin
      e = q.pop_front();
      nCmp++;
      if (oMax !== e.mx) begin
        nBad++;
        $display("FAIL %s_max: got %0d required %0d", nm, oMax, e.mx);
      end
      nCmp++;
      if (oMin !== e.mn) begin
        nBad++;
        $display("FAIL %s_min: got %0d required %0d", nm, oMin, e.mn);
      end
      nCmp++;
      if (oMaxIdx !== e.idx) begin
        nBad++;
        $display("FAIL %s_idx: got %0d required %0d", nm, oMaxIdx, e.idx);
      end
      nCmp++;
      if (oCmp !== e.cmp) begin
        nBad++;
        $display("FAIL %s_cmp: got %b required %b", nm, oCmp, e.cmp);
      end
      @(posedge iClk);
      #1;
      nCmp++;
      if (oValid !== 1'b0 || oReady !== 1'b1) begin
        nBad++;
        $display("FAIL %s_handoff: oValid=%0b oReady=%0b required 0/1",
                 nm, oValid, oReady);
      end
    end
  endtask

  task automatic checkResetVals(input string nm);
    nCmp++;
    if (oMax !== 8'h00 || oMin !== 8'hFF || oMaxIdx !== 8'h00 ||
        oCmp !== 3'b001 || oValid !== 1'b0 || oReady !== 1'b1) begin
      nBad++;
      $display("FAIL %s: max=%0h min=%0h idx=%0h cmp=%b v=%0b r=%0b required 0/ff/0/001/0/1",
               nm, oMax, oMin, oMaxIdx, oCmp, oValid, oReady);
    end
  endtask

  task automatic test_reset();
    iRst = 1'b1;
    repeat (2) @(negedge iClk);
    checkResetVals("reset_held");
    iRst = 1'b0;
    #1;
    checkResetVals("reset_release");
  endtask

  task automatic test_basic();
    iReady = 1'b1;
    send(5); send(9); send(3); send(9);
    getResult("s1");
  endtask

  task automatic test_equal();
    send(7); send(7); send(7); send(7);
    getResult("s2");
  endtask

  task automatic test_hold();
    int n;
    res_t e;
    iReady = 1'b0;
    send(0); send(255); send(1); send(0);
    n = 0;
    while (!oValid && n < 20) begin
      @(negedge iClk);
      n++;
    end
    e = q[0];
    for (int i = 0; i < 5; i++) begin
      @(negedge iClk);
      nCmp++;
      if (oValid !== 1'b1 || oReady !== 1'b0 || oMax !== e.mx ||
          oMin !== e.mn || oMaxIdx !== e.idx || oCmp !== e.cmp) begin
        nBad++;
        $display("FAIL s3_hold%0d: v=%0b r=%0b max=%0d min=%0d idx=%0d cmp=%b required 1/0/%0d/%0d/%0d/%b",
                 i, oValid, oReady, oMax, oMin, oMaxIdx, oCmp,
                 e.mx, e.mn, e.idx, e.cmp);
      end
      iValid = 1'b1;
      iData = 8'($urandom_range(0, 255));
    end
    @(negedge iClk);
    iValid = 1'b0;
    iReady = 1'b1;
    getResult("s3");
    send(9); send(1); send(2); send(3);
    getResult("s3_next");
  endtask

  task automatic test_gaps();
    send(2); idle(); send(8); send(4); idle(); send(1);
    getResult("s4");
  endtask

  task automatic test_reset_mid();
    send(10); send(20);
    #3;
    iRst = 1'b1;
    #1;
    checkResetVals("s5_async");
    mCnt = 0;
    @(negedge iClk);
    iRst = 1'b0;
    send(3); send(1); send(2); send(6);
    getResult("s5");
  endtask

  task automatic test_back_to_back();
    send(1); send(2); send(3); send(4);
    getResult("s6a");
    send(4); send(3); send(2); send(1);
    getResult("s6b");
    nCmp++;
    if (q.size() != 0) begin
      nBad++;
      $display("FAIL s6_queue: %0d left required 0", q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_equal();
    test_hold();
    test_gaps();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
